// File: rtl/updown_counter_pkg.sv
// ---------------------------------------------------------------------------
// updown_counter_pkg
//   Shared definitions for updown_counter_param.
//   - CNT_MODE_WRAP / CNT_MODE_SAT : boundary-mode selectors for SATURATE.
//   - CNT_WIDTH_MIN / CNT_WIDTH_MAX : legal counter width range.
//   - cnt_default_max(width)       : default terminal value, 2**width-1.
// ---------------------------------------------------------------------------
package updown_counter_pkg;

  localparam bit CNT_MODE_WRAP = 1'b0;
  localparam bit CNT_MODE_SAT  = 1'b1;

  localparam int unsigned CNT_WIDTH_MIN = 1;
  localparam int unsigned CNT_WIDTH_MAX = 32;

  // Computed in 64 bits so that width=32 does not overflow.
  function automatic longint unsigned cnt_default_max(input int unsigned width);
    return (64'd1 << width) - 64'd1;
  endfunction

endpackage

// File: rtl/updown_counter_param.sv
// ---------------------------------------------------------------------------
// updown_counter_param
//   Parametrised modulo-N up/down counter with wrap or saturate mode,
//   count enable, synchronous clamped parallel load, boundary flags,
//   a registered terminal-count pulse and sticky overflow/underflow flags.
//
// Parameters
//   WIDTH     counter width, 1..32
//   MAX_VAL   terminal (highest) count, 1..2**WIDTH-1
//   SATURATE  CNT_MODE_WRAP (modulo MAX_VAL+1) or CNT_MODE_SAT (hold at bound)
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   en         in   count enable
//   up         in   direction, 1 = increment, 0 = decrement
//   load       in   synchronous parallel load (priority over en)
//   load_val   in   value to load, clamped to MAX_VAL
//   clr_flags  in   synchronous clear of ovf/unf (a same-edge set wins)
//   cout       out  registered count
//   at_max     out  cout == MAX_VAL (combinational)
//   at_min     out  cout == 0 (combinational)
//   tc         out  one-cycle pulse after each boundary step
//   ovf        out  sticky: increment attempted at MAX_VAL
//   unf        out  sticky: decrement attempted at 0
// ---------------------------------------------------------------------------
module updown_counter_param
  import updown_counter_pkg::*;
#(
  parameter int unsigned     WIDTH    = 4,
  parameter longint unsigned MAX_VAL  = cnt_default_max(WIDTH),
  parameter bit              SATURATE = CNT_MODE_WRAP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] cout,
  output logic             at_max,
  output logic             at_min,
  output logic             tc,
  output logic             ovf,
  output logic             unf
);

  // Elaboration-time legality checks on the parameters.
  if (WIDTH < CNT_WIDTH_MIN || WIDTH > CNT_WIDTH_MAX) begin : g_bad_width
    $error("updown_counter_param: WIDTH must be in 1..32");
  end
  if (MAX_VAL < 1 || MAX_VAL > cnt_default_max(WIDTH)) begin : g_bad_max
    $error("updown_counter_param: MAX_VAL must be in 1..2**WIDTH-1");
  end

  localparam logic [WIDTH-1:0] MAX_C = MAX_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE_C = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO_C = '0;

  logic             step;
  logic             ovf_evt;
  logic             unf_evt;
  logic [WIDTH-1:0] load_clamped;

  assign at_max = (cout == MAX_C);
  assign at_min = (cout == ZERO_C);

  // A count step only happens when load does not take priority.
  assign step    = en & ~load;
  assign ovf_evt = step &  up & at_max;
  assign unf_evt = step & ~up & at_min;

  assign load_clamped = (load_val > MAX_C) ? MAX_C : load_val;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cout <= '0;
      tc   <= 1'b0;
      ovf  <= 1'b0;
      unf  <= 1'b0;
    end else begin
      if (load) begin
        cout <= load_clamped;
      end else if (en) begin
        if (up) begin
          if (!at_max)
            cout <= cout + ONE_C;
          else if (SATURATE == CNT_MODE_WRAP)
            cout <= ZERO_C;
        end else begin
          if (!at_min)
            cout <= cout - ONE_C;
          else if (SATURATE == CNT_MODE_WRAP)
            cout <= MAX_C;
        end
      end

      // Saturated with en held high keeps raising an event every cycle,
      // so tc stays high on each of those cycles.
      tc <= ovf_evt | unf_evt;

      // A new event on the same edge as clr_flags leaves the flag set.
      ovf <= ovf_evt | (ovf & ~clr_flags);
      unf <= unf_evt | (unf & ~clr_flags);
    end
  end

endmodule

// File: tb/tb_updown_counter_param.sv
// ---------------------------------------------------------------------------
// tb_updown_counter_param
//   Directed bench for updown_counter_param, WIDTH=4, MAX_VAL=9.
//   dut_w runs in wrap mode and dut_s in saturate mode; both share stimulus.
// ---------------------------------------------------------------------------
module tb_updown_counter_param;

  logic       clk;
  logic       reset;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] load_val;
  logic       clr_flags;

  logic [3:0] cout_w, cout_s;
  logic       at_max_w, at_min_w, tc_w, ovf_w, unf_w;
  logic       at_max_s, at_min_s, tc_s, ovf_s, unf_s;

  int checks = 0;
  int errors = 0;

  updown_counter_param #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b0)) dut_w (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(load_val), .clr_flags(clr_flags), .cout(cout_w),
    .at_max(at_max_w), .at_min(at_min_w), .tc(tc_w), .ovf(ovf_w), .unf(unf_w)
  );

  updown_counter_param #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b1)) dut_s (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(load_val), .clr_flags(clr_flags), .cout(cout_s),
    .at_max(at_max_s), .at_min(at_min_s), .tc(tc_s), .ovf(ovf_s), .unf(unf_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; up = 1'b0; load = 1'b0;
    load_val = 4'd0; clr_flags = 1'b0;
    #12;
    chk("rst_cout", 32'(cout_w), 0);
    chk("rst_tc",   32'(tc_w),   0);
    chk("rst_ovf",  32'(ovf_w),  0);
    chk("rst_unf",  32'(unf_w),  0);
    chk("rst_at_min", 32'(at_min_w), 1);
    reset = 1'b1;

    // 1: count up through the 9 -> 0 wrap
    en = 1'b1; up = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk($sformatf("up_cout_%0d", i), 32'(cout_w), i % 10);
      chk($sformatf("up_tc_%0d", i),   32'(tc_w),   (i == 10) ? 1 : 0);
      if (i == 9) chk("up_at_max", 32'(at_max_w), 1);
    end
    chk("up_ovf", 32'(ovf_w), 1);
    chk("up_unf", 32'(unf_w), 0);

    // 2: load 0 (clearing flags), then decrement with wrap
    en = 1'b0; load = 1'b1; load_val = 4'd0; clr_flags = 1'b1;
    tick();
    chk("ld0_cout", 32'(cout_w), 0);
    chk("ld0_ovf",  32'(ovf_w),  0);
    chk("ld0_tc",   32'(tc_w),   0);
    load = 1'b0; clr_flags = 1'b0; en = 1'b1; up = 1'b0;
    tick();
    chk("dn_cout_1", 32'(cout_w), 9);
    chk("dn_tc_1",   32'(tc_w),   1);
    tick();
    chk("dn_cout_2", 32'(cout_w), 8);
    chk("dn_tc_2",   32'(tc_w),   0);
    tick();
    chk("dn_cout_3", 32'(cout_w), 7);
    chk("dn_unf",    32'(unf_w),  1);
    chk("dn_ovf",    32'(ovf_w),  0);

    // 3: load 8, count up; saturate holds at 9, wrap rolls over
    en = 1'b0; load = 1'b1; load_val = 4'd8; clr_flags = 1'b1;
    tick();
    chk("sat_ld_cout", 32'(cout_s), 8);
    chk("sat_ld_ovf",  32'(ovf_s),  0);
    load = 1'b0; clr_flags = 1'b0; en = 1'b1; up = 1'b1;
    tick();
    chk("sat_cout_1", 32'(cout_s), 9);
    chk("sat_tc_1",   32'(tc_s),   0);
    chk("wrp_cout_1", 32'(cout_w), 9);
    tick();
    chk("sat_cout_2", 32'(cout_s), 9);
    chk("sat_tc_2",   32'(tc_s),   1);
    chk("wrp_cout_2", 32'(cout_w), 0);
    chk("wrp_tc_2",   32'(tc_w),   1);
    tick();
    chk("sat_cout_3", 32'(cout_s), 9);
    chk("sat_tc_3",   32'(tc_s),   1);
    chk("sat_ovf",    32'(ovf_s),  1);
    chk("wrp_cout_3", 32'(cout_w), 1);
    chk("wrp_tc_3",   32'(tc_w),   0);
    en = 1'b0;
    tick();
    chk("sat_hold_cout", 32'(cout_s), 9);
    chk("sat_hold_tc",   32'(tc_s),   0);

    // 4: clamped load wins over a simultaneous decrement
    load = 1'b1; load_val = 4'd14; en = 1'b1; up = 1'b0; clr_flags = 1'b1;
    tick();
    chk("clamp_cout_w", 32'(cout_w), 9);
    chk("clamp_cout_s", 32'(cout_s), 9);
    chk("clamp_tc",     32'(tc_w),   0);
    chk("clamp_unf",    32'(unf_w),  0);
    load_val = 4'd3; clr_flags = 1'b0;
    tick();
    chk("ld3_cout", 32'(cout_w), 3);
    load_val = 4'd9;
    tick();
    chk("ld9_cout", 32'(cout_w), 9);

    // 5: set beats clear on the same edge; clear alone then drops ovf
    load = 1'b0; en = 1'b1; up = 1'b1; clr_flags = 1'b1;
    tick();
    chk("clr_set_cout", 32'(cout_w), 0);
    chk("clr_set_ovf",  32'(ovf_w),  1);
    chk("clr_set_tc",   32'(tc_w),   1);
    en = 1'b0;
    tick();
    chk("clr_only_ovf", 32'(ovf_w), 0);
    chk("clr_only_tc",  32'(tc_w),  0);
    clr_flags = 1'b0;

    // 6: async reset mid-count at cout=5
    load = 1'b1; load_val = 4'd9;
    tick();
    load = 1'b0; en = 1'b1; up = 1'b1;
    tick();
    chk("pre_rst_ovf", 32'(ovf_w), 1);
    load = 1'b1; load_val = 4'd4; en = 1'b0;
    tick();
    load = 1'b0; en = 1'b1; up = 1'b1;
    tick();
    chk("pre_rst_cout", 32'(cout_w), 5);
    #3 reset = 1'b0;
    #1;
    chk("mid_rst_cout", 32'(cout_w), 0);
    chk("mid_rst_tc",   32'(tc_w),   0);
    chk("mid_rst_ovf",  32'(ovf_w),  0);
    chk("mid_rst_unf",  32'(unf_w),  0);
    tick();
    chk("held_rst_cout", 32'(cout_w), 0);
    reset = 1'b1;
    tick();
    chk("resume_cout_1", 32'(cout_w), 1);
    tick();
    chk("resume_cout_2", 32'(cout_w), 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/updown_counter_param.md
Name: updown_counter_param

Overview:
- Parametrised up/down counter; next generation of the team's 4-bit up/down counter.
- Adds the following over that counter:
  - configurable width and terminal value (modulo-N);
  - wrap or saturate mode;
  - count enable and synchronous parallel load;
  - boundary flags, a terminal-count pulse and sticky overflow/underflow flags.
- Used as a general event/position counter in sequential datapaths and as a modulo timebase.

Parameters:
- WIDTH, 4: counter width in bits; legal range 1..32.
- MAX_VAL, 2**WIDTH-1: terminal (highest) count value; legal range 1..2**WIDTH-1.
- SATURATE, 0: boundary mode. 0 = wrap (modulo MAX_VAL+1). 1 = saturate (hold at bound).

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  count enable; counter changes by one step only when en=1.
- up  input  1  direction, sampled with en: 1 = increment, 0 = decrement.
- load  input  1  synchronous parallel load strobe.
- load_val  input  WIDTH  value to load.
- clr_flags  input  1  synchronous clear for ovf/unf.
- cout  output  WIDTH  current count (registered).
- at_max  output  1  combinational; 1 when cout==MAX_VAL.
- at_min  output  1  combinational; 1 when cout==0.
- tc  output  1  registered one-cycle terminal-count pulse.
- ovf  output  1  sticky: an increment was attempted at MAX_VAL.
- unf  output  1  sticky: a decrement was attempted at 0.

Behaviour:
- Reset:
  - reset=0 clears cout, tc, ovf and unf to 0 immediately, independent of clk.
  - Deassertion is synchronised by the integrator; the block itself has no reset synchroniser.
  - Reset asserted mid-count discards the count with no partial update.
- Per-edge priority (reset=1): load > en > hold.
- Load:
  - load=1 sets cout <= load_val; if load_val > MAX_VAL, cout <= MAX_VAL (clamped).
  - Load never sets tc, ovf or unf.
  - en and up are ignored during the load cycle.
- Count, en=1 and load=0:
  - up=1, cout<MAX_VAL: cout+1.
  - up=1, cout==MAX_VAL: wrap mode cout<=0; saturate mode cout holds MAX_VAL. In both modes tc<=1 for the next cycle and ovf<=1.
  - up=0, cout>0: cout-1.
  - up=0, cout==0: wrap mode cout<=MAX_VAL; saturate mode cout holds 0. In both modes tc<=1 and unf<=1.
- Hold: en=0 and load=0 keeps cout unchanged; tc<=0.
- tc timing:
  - tc is high for exactly the one cycle following the edge at which the boundary step occurred.
  - Back-to-back boundary steps (e.g. saturated and en held high) keep tc high on every such cycle.
- Flags:
  - ovf and unf stay set until clr_flags=1 or reset.
  - If clr_flags and a new boundary event occur on the same edge, the set wins and the flag stays 1.
- Latency: cout reflects load or count one clock after the sampling edge. at_max and at_min follow cout with zero added latency.
- Direction: up may change on any cycle; there is no turnaround penalty.
- Arithmetic: all comparisons are unsigned, at WIDTH bits. MAX_VAL is evaluated at elaboration. Illegal parameter values trigger an elaboration-time error.

Decomposition:
- Shared package updown_counter_pkg holds:
  - mode constants CNT_MODE_WRAP=0 and CNT_MODE_SAT=1;
  - a function computing the default terminal value from WIDTH.
- No sub-module is needed. The next-state logic and the boundary detect stay in one always block plus continuous assigns.

Test Plan (WIDTH=4, MAX_VAL=9 unless stated):
1. Reset, then en=1 up=1 for 12 cycles (wrap) -> cout 0..9,0,1; tc=1 for exactly one cycle after the 9->0 step; ovf=1, unf=0.
2. Decrement from 0 in wrap mode, en=1 up=0 for 3 cycles -> cout 9,8,7; unf=1; tc pulses once.
3. SATURATE=1, load_val=8, then up for 3 cycles -> cout 8,9,9,9; tc high on both cycles after saturation; ovf=1.
4. load=1 with load_val=14 and en=1 up=0 together -> cout=9 (clamped); no tc; en ignored.
5. clr_flags=1 on the same edge as a 9->0 wrap -> ovf stays 1. clr_flags alone on the next cycle -> ovf=0.
6. Assert reset low mid-count at cout=5, between clock edges -> cout=0, tc=0, ovf=0 and unf=0 immediately. Release reset -> counting resumes from 0.
